// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, requester indices and default bus widths.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two memory requesters.
// DMEM_ARBITER_RR_EN: round-robin on contention; otherwise the CPU port wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef DMEM_ARBITER_RR_EN
  input  logic       last_i,
`endif
  output logic       vld_o,
  output logic       win_o
);

  always_comb begin
    vld_o = |req_i;
    win_o = PORT_CPU;
    if (req_i == 2'b11) begin
`ifdef DMEM_ARBITER_RR_EN
      // The port that was not served last gets the slot.
      win_o = ~last_i;
`else
      win_o = PORT_CPU;
`endif
    end else if (req_i[1]) begin
      win_o = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256-byte data memory: gnt one cycle after the
// latching edge, ack the cycle after; DMEM_ARBITER_RR_EN selects round-robin contention.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              win_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef DMEM_ARBITER_RR_EN
  logic              last_q;
`endif

  logic              pick_vld;
  logic              pick_win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_arb_pick u_pick (
    .req_i  ({req1, req0}),
`ifdef DMEM_ARBITER_RR_EN
    .last_i (last_q),
`endif
    .vld_o  (pick_vld),
    .win_o  (pick_win)
  );

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (pick_win == PORT_DBG) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // RESP re-arbitrates like IDLE so back-to-back accesses run every two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      win_q   <= PORT_CPU;
      rdata_q <= '0;
`ifdef DMEM_ARBITER_RR_EN
      last_q  <= PORT_CPU;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (pick_vld) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            win_q   <= pick_win;
`ifdef DMEM_ARBITER_RR_EN
            last_q  <= pick_win;
`endif
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from registers only, so an async reset kills them at once.
  assign gnt0      = (state_q == ST_ACCESS) && (win_q == PORT_CPU);
  assign gnt1      = (state_q == ST_ACCESS) && (win_q == PORT_DBG);
  assign ack0      = (state_q == ST_RESP)   && (win_q == PORT_CPU);
  assign ack1      = (state_q == ST_RESP)   && (win_q == PORT_DBG);
  assign mem_write = (state_q == ST_ACCESS) &&  we_q;
  assign mem_read  = (state_q == ST_ACCESS) && !we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
